// File: rtl/drbg_pkg.sv
// Shared encodings for the DRBG command scheduler: core commands, FSM states
// and the default reseed interval.
package drbg_pkg;

  typedef enum logic [1:0] {
    CmdInit     = 2'b00,
    CmdReseed   = 2'b01,
    CmdGenerate = 2'b10
  } drbg_cmd_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10
  } sched_state_e;

  localparam int unsigned DefaultReseedInterval = 480;
  localparam int unsigned ReseedCountWidth      = 32;

endpackage

// File: rtl/drbg_reseed_counter.sv
// Generates-since-reseed counter: saturating increment, clear, and the
// reseed-due compare gated by reseed_block.
module drbg_reseed_counter
  import drbg_pkg::*;
#(
  parameter int unsigned RESEED_INTERVAL = DefaultReseedInterval
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic incr,
  input  logic reseed_block,
  output logic due
);

  logic [ReseedCountWidth-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (incr && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign due = (count_q >= ReseedCountWidth'(RESEED_INTERVAL)) && !reseed_block;

endmodule

// File: rtl/drbg_scheduler.sv
// DRBG command scheduler: arbitrates init, reseed and generate commands to the core.
// Optional watchdog on the WAIT state is compiled in with DRBG_SCHED_WATCHDOG_EN.
module drbg_scheduler
  import drbg_pkg::*;
#(
  parameter int unsigned RESEED_INTERVAL = DefaultReseedInterval,
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_req,
  input  logic        line_req,
  input  logic        catch_up_req,
  input  logic        reseed_block,
  input  logic        core_done,
  output logic        core_start,
  output logic [1:0]  core_cmd,
  output logic        init_done,
  output logic        line_ack,
  output logic        catch_up_ack,
  // "sequence" is a reserved word, hence the suffix.
  output logic [31:0] sequence_count,
  output logic        line_overrun,
  output logic        busy
`ifdef DRBG_SCHED_WATCHDOG_EN
  ,
  output logic        timeout_err
`endif
);

  sched_state_e state_q, state_d;
  drbg_cmd_e    cmd_q, cmd_d;
  logic         owner_cu_q, owner_cu_d;
  logic         pending_q, pending_d;
  logic         init_done_q, init_done_d;
  logic [31:0]  seq_q, seq_d;
  logic         line_ack_q, line_ack_d;
  logic         cu_ack_q, cu_ack_d;
  logic         overrun_q, overrun_d;
  logic         cnt_clear, cnt_incr, reseed_due;
  logic         issue_line;

`ifdef DRBG_SCHED_WATCHDOG_EN
  logic [31:0]  wd_cnt_q, wd_cnt_d;
  logic         timeout_q, timeout_d;
`else
  logic         unused_watchdog;
  assign unused_watchdog = ^WATCHDOG_CYCLES;
`endif

  drbg_reseed_counter #(
    .RESEED_INTERVAL(RESEED_INTERVAL)
  ) u_reseed_counter (
    .clk         (clk),
    .reset       (reset),
    .clear       (cnt_clear),
    .incr        (cnt_incr),
    .reseed_block(reseed_block),
    .due         (reseed_due)
  );

  assign issue_line = (state_q == StIssue) && (cmd_q == CmdGenerate) && !owner_cu_q;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    owner_cu_d  = owner_cu_q;
    pending_d   = pending_q;
    init_done_d = init_done_q;
    seq_d       = seq_q;
    line_ack_d  = 1'b0;
    cu_ack_d    = 1'b0;
    overrun_d   = 1'b0;
    cnt_clear   = 1'b0;
    cnt_incr    = 1'b0;
`ifdef DRBG_SCHED_WATCHDOG_EN
    wd_cnt_d    = wd_cnt_q;
    timeout_d   = timeout_q;
`endif

    // A request landing on the issue cycle of the held line re-arms the flag.
    if (issue_line) pending_d = 1'b0;
    if (line_req) begin
      if (pending_q && !issue_line) overrun_d = 1'b1;
      else                          pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (init_req) begin
          cmd_d   = CmdInit;
          state_d = StIssue;
        end else if (init_done_q && reseed_due) begin
          cmd_d   = CmdReseed;
          state_d = StIssue;
        end else if (init_done_q && catch_up_req) begin
          cmd_d      = CmdGenerate;
          owner_cu_d = 1'b1;
          state_d    = StIssue;
        end else if (init_done_q && pending_q) begin
          cmd_d      = CmdGenerate;
          owner_cu_d = 1'b0;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
        if (cmd_q == CmdInit) init_done_d = 1'b0;
`ifdef DRBG_SCHED_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
      end
      StWait: begin
        if (core_done) begin
          state_d = StIdle;
          unique case (cmd_q)
            CmdInit: begin
              init_done_d = 1'b1;
              seq_d       = '0;
              cnt_clear   = 1'b1;
            end
            CmdReseed: cnt_clear = 1'b1;
            CmdGenerate: begin
              seq_d    = seq_q + 32'd1;
              cnt_incr = 1'b1;
              if (owner_cu_q) cu_ack_d   = 1'b1;
              else            line_ack_d = 1'b1;
            end
            default: ;
          endcase
`ifdef DRBG_SCHED_WATCHDOG_EN
        end else if (wd_cnt_q == 32'(WATCHDOG_CYCLES - 1)) begin
          state_d     = StIdle;
          timeout_d   = 1'b1;
          init_done_d = 1'b0;
        end else begin
          wd_cnt_d = wd_cnt_q + 32'd1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_q       <= CmdInit;
      owner_cu_q  <= 1'b0;
      pending_q   <= 1'b0;
      init_done_q <= 1'b0;
      seq_q       <= '0;
      line_ack_q  <= 1'b0;
      cu_ack_q    <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef DRBG_SCHED_WATCHDOG_EN
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      owner_cu_q  <= owner_cu_d;
      pending_q   <= pending_d;
      init_done_q <= init_done_d;
      seq_q       <= seq_d;
      line_ack_q  <= line_ack_d;
      cu_ack_q    <= cu_ack_d;
      overrun_q   <= overrun_d;
`ifdef DRBG_SCHED_WATCHDOG_EN
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign core_start     = (state_q == StIssue);
  assign core_cmd       = cmd_q;
  assign busy           = (state_q != StIdle);
  assign init_done      = init_done_q;
  assign line_ack       = line_ack_q;
  assign catch_up_ack   = cu_ack_q;
  assign line_overrun   = overrun_q;
  assign sequence_count = seq_q;
`ifdef DRBG_SCHED_WATCHDOG_EN
  assign timeout_err    = timeout_q;
`endif

endmodule

// File: tb/tb_drbg_scheduler.sv
// Self-checking bench for drbg_scheduler: directed steps plus a randomized phase,
// checked against a command-log model of the scheduling rules.
module tb_drbg_scheduler;

  localparam int unsigned Interval = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_req = 1'b0;
  logic        line_req = 1'b0;
  logic        catch_up_req = 1'b0;
  logic        reseed_block = 1'b0;
  logic        core_done;
  logic        core_start;
  logic [1:0]  core_cmd;
  logic        init_done;
  logic        line_ack;
  logic        catch_up_ack;
  logic [31:0] sequence_count;
  logic        line_overrun;
  logic        busy;
`ifdef DRBG_SCHED_WATCHDOG_EN
  logic        timeout_err;
`endif

  always #5 clk = ~clk;

  drbg_scheduler #(
    .RESEED_INTERVAL(Interval),
    .WATCHDOG_CYCLES(1024)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .init_req      (init_req),
    .line_req      (line_req),
    .catch_up_req  (catch_up_req),
    .reseed_block  (reseed_block),
    .core_done     (core_done),
    .core_start    (core_start),
    .core_cmd      (core_cmd),
    .init_done     (init_done),
    .line_ack      (line_ack),
    .catch_up_ack  (catch_up_ack),
    .sequence_count(sequence_count),
    .line_overrun  (line_overrun),
    .busy          (busy)
`ifdef DRBG_SCHED_WATCHDOG_EN
    ,
    .timeout_err   (timeout_err)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Core responder / monitor state (written only by the responder process).
  logic [1:0] issued[$];
  int resp_pend = 0;
  int stray_seen = 0;
  int line_ack_cnt = 0;
  int cu_ack_cnt = 0;
  int overrun_cnt = 0;

  // Responder controls (written only by the main process).
  int resp_lat = 5;
  bit resp_en = 1'b1;
  int stray_req = 0;

  // Reference model: expected command log and counters.
  logic [1:0] expected[$];
  int log_idx = 0;
  int m_seq = 0;
  int m_cnt = 0;
  bit m_blk = 1'b0;

  initial begin : responder
    core_done = 1'b0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (line_ack) line_ack_cnt++;
      if (catch_up_ack) cu_ack_cnt++;
      if (line_overrun) overrun_cnt++;
      if (core_start) begin
        issued.push_back(core_cmd);
        resp_pend = resp_en ? resp_lat : 0;
      end else if (resp_pend > 0) begin
        resp_pend--;
        if (resp_pend == 0) core_done = 1'b1;
      end
      if (stray_seen != stray_req) begin
        stray_seen = stray_req;
        core_done  = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_line();
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    int q = 0;
    int t = 0;
    while (q < 4 && t < 3000) begin
      @(negedge clk);
      t++;
      q = busy ? 0 : q + 1;
    end
    chk({tag, "_quiet"}, 32'(q >= 4), 32'd1);
  endtask

  task automatic wait_issued(input int n, input string tag);
    int t = 0;
    while (issued.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_issued"}, 32'(issued.size() >= n), 32'd1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, 32'(issued.size()), 32'(expected.size()));
    for (int i = log_idx; i < expected.size() && i < issued.size(); i++) begin
      chk($sformatf("%s_cmd%0d", tag, i), 32'(issued[i]), 32'(expected[i]));
    end
    log_idx = expected.size();
  endtask

  task automatic m_init();
    expected.push_back(2'b00);
    m_seq = 0;
    m_cnt = 0;
  endtask

  // One completed generate; a reseed follows as soon as the interval is reached.
  task automatic m_gen();
    expected.push_back(2'b10);
    m_seq++;
    m_cnt++;
    if (m_cnt >= Interval && !m_blk) begin
      expected.push_back(2'b01);
      m_cnt = 0;
    end
  endtask

  task automatic m_unblock();
    m_blk = 1'b0;
    if (m_cnt >= Interval) begin
      expected.push_back(2'b01);
      m_cnt = 0;
    end
  endtask

  task automatic do_init(input string tag);
    init_req = 1'b1;
    wait_issued(issued.size() + 1, tag);
    init_req = 1'b0;
    m_init();
  endtask

  initial begin : main
    int n0, ov0, la0, cu0, ncu, t;

    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_seq", sequence_count, 32'd0);
    chk("rst_start", 32'(core_start), 32'd0);
    chk("rst_pulses", {29'd0, line_ack, catch_up_ack, line_overrun}, 32'd0);

    // Stray core_done while idle is ignored.
    stray_req++;
    tick(5);
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_none", 32'(issued.size()), 32'd0);

    // Line request before instantiate is held, not issued.
    pulse_line();
    tick(20);
    chk("pre_init_no_issue", 32'(issued.size()), 32'd0);

    // Instantiate with 5-cycle done latency; the held line follows.
    resp_lat = 5;
    do_init("init");
    t = 0;
    while (!init_done && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("init_done_rise", 32'(init_done), 32'd1);
    chk("init_seq_zero", sequence_count, 32'd0);
    m_gen();
    wait_quiet("init");
    check_log("init");
    chk("init_seq", sequence_count, 32'(m_seq));
    chk("init_line_ack", 32'(line_ack_cnt), 32'd1);

    // Three spaced line requests, latency 10.
    resp_lat = 10;
    la0 = line_ack_cnt;
    for (int i = 0; i < 3; i++) begin
      pulse_line();
      m_gen();
      tick(200);
    end
    check_log("spaced");
    chk("spaced_acks", 32'(line_ack_cnt - la0), 32'd3);

    // Fresh instantiate, five lines: G,G,G,G,R,G.
    do_init("reinit");
    wait_quiet("reinit");
    for (int i = 0; i < 5; i++) begin
      pulse_line();
      m_gen();
      wait_quiet("ggggrg");
    end
    check_log("ggggrg");
    chk("ggggrg_seq", sequence_count, 32'(m_seq));

    // Two line requests two cycles apart during WAIT: one overrun, one generate.
    resp_lat = 20;
    ov0 = overrun_cnt;
    n0 = issued.size();
    pulse_line();
    m_gen();
    wait_issued(n0 + 1, "ovr");
    tick(2);
    pulse_line();
    tick(1);
    pulse_line();
    m_gen();
    wait_quiet("ovr");
    chk("ovr_count", 32'(overrun_cnt - ov0), 32'd1);
    check_log("ovr");

    // Request on the issue cycle re-arms the flag without overrun.
    resp_lat = 6;
    ov0 = overrun_cnt;
    line_req = 1'b1;
    tick(1);
    line_req = 1'b0;
    tick(1);
    chk("issue_slot_start", 32'(core_start), 32'd1);
    chk("issue_slot_cmd", 32'(core_cmd), 32'd2);
    line_req = 1'b1;
    tick(1);
    line_req = 1'b0;
    m_gen();
    m_gen();
    wait_quiet("rearm");
    chk("rearm_no_ovr", 32'(overrun_cnt - ov0), 32'd0);
    check_log("rearm");

    // Reseed blocked: generates continue, reseed only after release.
    reseed_block = 1'b1;
    m_blk = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse_line();
      m_gen();
      wait_quiet("blk");
    end
    check_log("blk");
    reseed_block = 1'b0;
    m_unblock();
    wait_quiet("unblk");
    check_log("unblk");
    chk("blk_seq", sequence_count, 32'(m_seq));

    // Catch-up wins over a pending line while held.
    resp_lat = 30;
    la0 = line_ack_cnt;
    cu0 = cu_ack_cnt;
    n0 = issued.size();
    pulse_line();
    m_gen();
    wait_issued(n0 + 1, "cu");
    tick(3);
    pulse_line();
    catch_up_req = 1'b1;
    ncu = 0;
    t = 0;
    while (ncu < 3 && t < 2000) begin
      @(negedge clk);
      t++;
      if (catch_up_ack) ncu++;
    end
    catch_up_req = 1'b0;
    chk("cu_served", 32'(ncu), 32'd3);
    chk("cu_line_held", 32'(line_ack_cnt - la0), 32'd1);
    for (int i = 0; i < 4; i++) m_gen();
    wait_quiet("cu");
    chk("cu_acks", 32'(cu_ack_cnt - cu0), 32'd3);
    chk("cu_line_acks", 32'(line_ack_cnt - la0), 32'd2);
    check_log("cu");

    // Reset mid-command abandons it; next command must be init.
    resp_lat = 40;
    n0 = issued.size();
    pulse_line();
    wait_issued(n0 + 1, "midrst");
    expected.push_back(2'b10);
    tick(5);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    m_seq = 0;
    m_cnt = 0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_init_done", 32'(init_done), 32'd0);
    chk("midrst_seq", sequence_count, 32'd0);
    pulse_line();
    tick(60);
    chk("midrst_no_issue", 32'(issued.size()), 32'(expected.size()));
    resp_lat = 5;
    do_init("midrst");
    m_gen();
    wait_quiet("midrst");
    check_log("midrst");
    chk("midrst_seq2", sequence_count, 32'(m_seq));

    // Randomized line traffic, latency and reseed blocking.
    for (int i = 0; i < 24; i++) begin
      resp_lat = $urandom_range(2, 15);
      if ($urandom_range(0, 3) == 0) begin
        if (m_blk) begin
          reseed_block = 1'b0;
          m_unblock();
        end else begin
          reseed_block = 1'b1;
          m_blk = 1'b1;
        end
      end
      tick($urandom_range(0, 3));
      pulse_line();
      m_gen();
      wait_quiet("rand");
    end
    reseed_block = 1'b0;
    m_unblock();
    wait_quiet("rand_end");
    check_log("rand");
    chk("rand_seq", sequence_count, 32'(m_seq));

`ifdef DRBG_SCHED_WATCHDOG_EN
    // Withheld core_done: timeout after WATCHDOG_CYCLES WAIT cycles.
    resp_en = 1'b0;
    n0 = issued.size();
    pulse_line();
    wait_issued(n0 + 1, "wd");
    expected.push_back(2'b10);
    tick(900);
    chk("wd_not_yet", 32'(timeout_err), 32'd0);
    tick(200);
    chk("wd_timeout", 32'(timeout_err), 32'd1);
    chk("wd_init_done", 32'(init_done), 32'd0);
    chk("wd_idle", 32'(busy), 32'd0);
    check_log("wd");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
